// File: rtl/icblbc_search_ctrl.sv
// Depth-first branch-and-bound search for the largest set of n-bit codes with
// pairwise Hamming distance >= min_dist, driving an external candidate-populate engine.
module icblbc_search_ctrl #(
    parameter int LVL_SHIFT  = 4,
    parameter int MAX_LEVELS = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] n,
    input  logic [3:0] min_dist,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [4:0] best_size,
    input  logic [3:0] best_rd_idx,
    output logic [7:0] best_code,
    output logic [15:0] nodes,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_wren,
    input  logic [7:0] mem_rdata,
    output logic [7:0] pop_code,
    output logic [7:0] pop_base_cand,
    output logic [7:0] pop_cand_len,
    output logic [7:0] pop_base_next,
    output logic [3:0] pop_min_dist,
    output logic       pop_start,
    input  logic       pop_complete,
    input  logic [7:0] pop_next_len
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SELECT, S_RD1, S_RD2, S_WAIT_POP, S_UPDATE, S_FINISH
    } state_e;

    localparam logic [3:0] LVL_N    = 4'(LVL_SHIFT);
    localparam logic [3:0] LAST_LVL = 4'(MAX_LEVELS - 1);

    state_e     state_q, state_d;
    logic [3:0] n_q, n_d, md_q, md_d, depth_q, depth_d;
    logic [7:0] init_cnt_q, init_cnt_d, next_len_q, next_len_d;
    logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [4:0] best_size_q, best_size_d;
    logic [15:0] nodes_q, nodes_d;
    logic [7:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic       mem_wren_q, mem_wren_d, pop_start_q, pop_start_d;
    logic [7:0] pop_code_q, pop_code_d, pop_bc_q, pop_bc_d;
    logic [7:0] pop_cl_q, pop_cl_d, pop_bn_q, pop_bn_d;
    logic [7:0] idx_q [MAX_LEVELS], idx_d [MAX_LEVELS];
    logic [7:0] len_q [MAX_LEVELS], len_d [MAX_LEVELS];
    logic [7:0] chosen_q [MAX_LEVELS], chosen_d [MAX_LEVELS];
    logic [7:0] best_set_q [MAX_LEVELS], best_set_d [MAX_LEVELS];

    logic [7:0] cur_idx, cur_len, init_len;
    logic [8:0] remain, bound;

    function automatic logic [7:0] base_of(input logic [4:0] lvl);
        return {3'b000, lvl} << LVL_SHIFT;
    endfunction

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through the case leaves a latch.
        state_d     = state_q;
        n_d         = n_q;
        md_d        = md_q;
        depth_d     = depth_q;
        init_cnt_d  = init_cnt_q;
        next_len_d  = next_len_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        best_size_d = best_size_q;
        nodes_d     = nodes_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wren_d  = 1'b0;
        pop_start_d = 1'b0;
        pop_code_d  = pop_code_q;
        pop_bc_d    = pop_bc_q;
        pop_cl_d    = pop_cl_q;
        pop_bn_d    = pop_bn_q;
        idx_d       = idx_q;
        len_d       = len_q;
        chosen_d    = chosen_q;
        best_set_d  = best_set_q;

        cur_idx  = idx_q[depth_q];
        cur_len  = len_q[depth_q];
        init_len = 8'd1 << n_q;
        // Bound on the final set size reachable from this level; meaningless once exhausted.
        remain   = {1'b0, cur_len} - {1'b0, cur_idx};
        bound    = {5'd0, depth_q} + remain;

        case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    n_d         = n;
                    md_d        = min_dist;
                    best_size_d = 5'd0;
                    nodes_d     = 16'd0;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    init_cnt_d  = 8'd0;
                    state_d     = (n > LVL_N) ? S_FINISH : S_INIT;
                end
            end
            S_INIT: begin
                mem_addr_d  = init_cnt_q;
                mem_wdata_d = init_cnt_q;
                mem_wren_d  = 1'b1;
                init_cnt_d  = init_cnt_q + 8'd1;
                if (init_cnt_q == init_len - 8'd1) begin
                    len_d[0] = init_len;
                    idx_d[0] = 8'd0;
                    depth_d  = 4'd0;
                    state_d  = S_SELECT;
                end
            end
            S_SELECT: begin
                if (cur_idx >= cur_len || bound <= {4'd0, best_size_q}) begin
                    if (depth_q == 4'd0) begin
                        state_d = S_FINISH;
                    end else begin
                        depth_d = depth_q - 4'd1;
                        idx_d[depth_q - 4'd1] = idx_q[depth_q - 4'd1] + 8'd1;
                    end
                end else begin
                    mem_addr_d = base_of({1'b0, depth_q}) + cur_idx;
                    state_d    = S_RD1;
                end
            end
            S_RD1: state_d = S_RD2;
            S_RD2: begin
                chosen_d[depth_q] = mem_rdata;
                if (depth_q == LAST_LVL) begin
                    next_len_d = 8'd0;
                    state_d    = S_UPDATE;
                end else begin
                    pop_code_d  = mem_rdata;
                    pop_bc_d    = base_of({1'b0, depth_q}) + cur_idx + 8'd1;
                    pop_cl_d    = cur_len - cur_idx - 8'd1;
                    pop_bn_d    = base_of({1'b0, depth_q} + 5'd1);
                    pop_start_d = 1'b1;
                    if (nodes_q != 16'hFFFF) nodes_d = nodes_q + 16'd1;
                    state_d = S_WAIT_POP;
                end
            end
            S_WAIT_POP: begin
                if (pop_complete) begin
                    len_d[depth_q + 4'd1] = pop_next_len;
                    next_len_d = pop_next_len;
                    state_d    = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if ({1'b0, depth_q} + 5'd1 > best_size_q) begin
                    best_size_d = {1'b0, depth_q} + 5'd1;
                    for (int i = 0; i < MAX_LEVELS; i++) begin
                        if (i <= int'(depth_q)) best_set_d[i] = chosen_q[i];
                    end
                end
                if (next_len_q == 8'd0) begin
                    idx_d[depth_q] = idx_q[depth_q] + 8'd1;
                end else begin
                    depth_d = depth_q + 4'd1;
                    idx_d[depth_q + 4'd1] = 8'd0;
                end
                state_d = S_SELECT;
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = (n_q > LVL_N);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            n_q         <= 4'd0;
            md_q        <= 4'd0;
            depth_q     <= 4'd0;
            init_cnt_q  <= 8'd0;
            next_len_q  <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            best_size_q <= 5'd0;
            nodes_q     <= 16'd0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= 8'd0;
            mem_wren_q  <= 1'b0;
            pop_start_q <= 1'b0;
            pop_code_q  <= 8'd0;
            pop_bc_q    <= 8'd0;
            pop_cl_q    <= 8'd0;
            pop_bn_q    <= 8'd0;
            idx_q       <= '{default: 8'd0};
            len_q       <= '{default: 8'd0};
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            md_q        <= md_d;
            depth_q     <= depth_d;
            init_cnt_q  <= init_cnt_d;
            next_len_q  <= next_len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            best_size_q <= best_size_d;
            nodes_q     <= nodes_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wren_q  <= mem_wren_d;
            pop_start_q <= pop_start_d;
            pop_code_q  <= pop_code_d;
            pop_bc_q    <= pop_bc_d;
            pop_cl_q    <= pop_cl_d;
            pop_bn_q    <= pop_bn_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
        end
    end

    // NOTE: chosen/best_set are storage arrays left unreset; best_code masks entries beyond best_size.
    always_ff @(posedge clock) begin
        chosen_q   <= chosen_d;
        best_set_q <= best_set_d;
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign best_size     = best_size_q;
    assign nodes         = nodes_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wren      = mem_wren_q;
    assign pop_code      = pop_code_q;
    assign pop_base_cand = pop_bc_q;
    assign pop_cand_len  = pop_cl_q;
    assign pop_base_next = pop_bn_q;
    assign pop_min_dist  = md_q;
    assign pop_start     = pop_start_q;
    assign best_code     = ({1'b0, best_rd_idx} < best_size_q) ? best_set_q[best_rd_idx] : 8'd0;

endmodule

// File: doc/icblbc_search_ctrl.md
Name: icblbc_search_ctrl

Overview:
- Depth-first branch-and-bound controller that searches for the largest set of n-bit codes with pairwise Hamming distance >= min_dist.
- Sits directly upstream of the candidate-populate engine:
  - seeds level 0 of the shared candidate RAM with all 2^n codes;
  - picks a code at each level and launches the engine to filter the remaining candidates into the next level;
  - consumes the engine's resulting list length.
- Tracks depth, per-level cursors and lengths, and backtracks.
- Reports the best set found.

Parameters:
- LVL_SHIFT, 4: log2 of the per-level region stride in RAM. Level k base address = k << LVL_SHIFT.
- MAX_LEVELS, 16: number of levels; must equal 256 >> LVL_SHIFT. This is also the cap on the set size.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a search. Ignored while busy.
- n  in  4  code width in bits. Sampled on start.
- min_dist  in  4  required minimum pairwise distance. Sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the search finishes.
- err  out  1  set with done when n > LVL_SHIFT; cleared on the next accepted start.
- best_size  out  5  size of the best set found (0..MAX_LEVELS).
- best_rd_idx  in  4  index into the best set.
- best_code  out  8  combinational read of best_set[best_rd_idx].
- nodes  out  16  count of pop_start pulses this search; saturates at 0xFFFF.
- mem_addr  out  8  candidate RAM address; controller side of the shared port.
- mem_wdata  out  8  candidate RAM write data.
- mem_wren  out  1  candidate RAM write enable.
- mem_rdata  in  8  candidate RAM read data.
- pop_code  out  8  code the engine filters against.
- pop_base_cand  out  8  address of the first source candidate.
- pop_cand_len  out  8  number of source candidates.
- pop_base_next  out  8  destination base address.
- pop_min_dist  out  4  equals the latched min_dist.
- pop_start  out  1  one-cycle launch pulse.
- pop_complete  in  1  engine finished; pop_next_len is valid this cycle.
- pop_next_len  in  8  number of candidates written to the destination.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state = IDLE;
  - busy, done, err, mem_wren, pop_start = 0;
  - best_size, nodes, mem_addr, mem_wdata, all pop_* data outputs = 0;
  - depth, cursors and lengths cleared.
  - Reset mid-search aborts immediately; an engine pop_complete arriving afterwards is ignored in IDLE.
- RAM timing: synchronous, single port. Top level muxes the port to the engine while the controller is in WAIT_POP.
  - Controller samples mem_rdata two edges after the edge that updates mem_addr (state RD1 then RD2).
- IDLE: on start, latch n and min_dist; clear best_size, nodes and err; busy = 1.
  - If n > LVL_SHIFT: pulse done with err = 1, best_size = 0, return to IDLE.
  - Else go to INIT.
- INIT: write codes 0 .. 2^n-1 to addresses 0 .. 2^n-1, one per cycle (mem_wren = 1).
  - len[0] = 2^n, depth = 0, idx[0] = 0, then go to SELECT.
- SELECT, evaluated in this priority order:
  - (a) If idx[depth] >= len[depth] or depth + (len[depth] - idx[depth]) <= best_size (prune):
    - depth = 0: go to FINISH;
    - otherwise: depth -= 1, idx[depth] += 1, stay in SELECT.
  - (b) Else set mem_addr = base(depth) + idx[depth] and go to RD1 -> RD2.
- RD2: chosen[depth] = mem_rdata. Drive the engine:
  - pop_code = mem_rdata;
  - pop_base_cand = base(depth) + idx[depth] + 1;
  - pop_cand_len = len[depth] - idx[depth] - 1;
  - pop_base_next = base(depth + 1).
  - Pulse pop_start; nodes += 1 (saturating). Go to WAIT_POP.
  - pop_* data outputs hold stable until pop_complete.
  - If depth = MAX_LEVELS-1: no launch; treat as pop_next_len = 0 and go directly to the UPDATE logic.
- WAIT_POP: on pop_complete, len[depth+1] = pop_next_len, go to UPDATE.
- UPDATE:
  - If depth + 1 > best_size: best_size = depth + 1 and best_set[0..depth] = chosen[0..depth] (same cycle).
  - If len[depth+1] = 0: idx[depth] += 1.
  - Else: depth += 1, idx[depth] = 0.
  - Go to SELECT.
- FINISH: busy = 0, pulse done for exactly one cycle, go to IDLE.
- Arithmetic:
  - All address sums are 8-bit and never wrap given the parameter constraint.
  - Cursors and lengths are 8-bit; depth is 4-bit with no wrap (the depth-limit rule guarantees this).
- best_set entries at or beyond best_size read as 0.
- The pop_complete pulse is honoured only in WAIT_POP.
- Simultaneous start and done: start is ignored (not busy only from the next cycle).

Test Plan (engine replaced by a behavioural model with variable 1-20 cycle latency):
- n=2, min_dist=2 -> done; best_size=2; best_code[0]=0x00, [1]=0x03; err=0.
- n=3, min_dist=2 -> best_size=4; best set {0x00,0x03,0x05,0x06} in index order.
- n=3, min_dist=3 -> best_size=2, set {0x00,0x07}. Then n=0, min_dist=1 -> best_size=1, code 0x00, nodes=1.
- n=4, min_dist=0 -> best_size=16 (depth cap honoured, no launch at depth 15); best_code[i]=i.
- n=5 (LVL_SHIFT=4) -> done and err in the cycle after busy rises; best_size=0; nodes=0; no mem_wren.
- Reset asserted during WAIT_POP of an n=3, min_dist=2 run:
  - all outputs at reset values next cycle;
  - a late pop_complete is ignored;
  - a fresh start reproduces best_size=4.
